// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types used by the ALU-side pipeline stages.
package cpu_pkg;

  localparam int unsigned ALU_WIDTH = 16;
  localparam int unsigned BYTE_W    = 8;

  typedef struct packed {
    logic zr;
    logic ng;
  } flags_t;

  function automatic int unsigned nbytes_of(input int unsigned width);
    return width / BYTE_W;
  endfunction

endpackage

// File: rtl/byte_or_reduce.sv
// Per-byte OR reduction: one 8-input OR per lane, purely combinational.
module byte_or_reduce
  import cpu_pkg::*;
#(
  parameter int unsigned NBYTES = ALU_WIDTH / BYTE_W
) (
  input  logic [NBYTES*BYTE_W-1:0] data,
  output logic [NBYTES-1:0]        bor
);

  always_comb begin
    bor = '0;
    for (int unsigned k = 0; k < NBYTES; k++) begin
      bor[k] = |data[k*BYTE_W +: BYTE_W];
    end
  end

endmodule

// File: rtl/alu_flag_stage.sv
// Two-stage registered zero/negative flag generator with valid/ready handshake,
// output transfer counter and sticky non-zero indicator.
module alu_flag_stage
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             zr,
  output logic             ng,
  input  logic             clr_sticky,
  output logic             sticky_nz,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int unsigned NBYTES = nbytes_of(WIDTH);

  logic              s1_valid;
  logic [WIDTH-1:0]  s1_data;
  logic [NBYTES-1:0] s1_bor;
  logic [NBYTES-1:0] in_bor;
  flags_t            flags_q;

  logic s2_free;
  logic s1_adv;
  logic capture;
  logic xfer;

  byte_or_reduce #(.NBYTES(NBYTES)) u_bor (
    .data (in_data),
    .bor  (in_bor)
  );

  // in_ready depends on out_ready and pipeline state only, never on in_valid.
  always_comb begin
    s2_free  = !out_valid || out_ready;
    s1_adv   = s1_valid && s2_free;
    in_ready = !s1_valid || s2_free;
    capture  = in_valid && in_ready;
    xfer     = out_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_bor    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      flags_q   <= '0;
      sticky_nz <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      if (capture) begin
        s1_data  <= in_data;
        s1_bor   <= in_bor;
        s1_valid <= 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        out_data   <= s1_data;
        flags_q.zr <= ~|s1_bor;
        flags_q.ng <= s1_data[WIDTH-1];
        out_valid  <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end

      if (xfer) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
      // A non-zero word leaving this cycle re-sets the flag even under a clear.
      sticky_nz <= (clr_sticky ? 1'b0 : sticky_nz) | (xfer && !flags_q.zr);
    end
  end

  assign zr = flags_q.zr;
  assign ng = flags_q.ng;

endmodule

// File: tb/tb_alu_flag_stage.sv
// Scoreboard bench for alu_flag_stage: accepted words are queued, transfers pop and compare.
module tb_alu_flag_stage;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         zr;
  logic         ng;
  logic         clr_sticky = 1'b0;
  logic         sticky_nz;
  logic [7:0]   xfer_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] sb[$];
  logic [7:0]   exp_cnt = '0;

  alu_flag_stage #(.WIDTH(W), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .zr         (zr),
    .ng         (ng),
    .clr_sticky (clr_sticky),
    .sticky_nz  (sticky_nz),
    .xfer_cnt   (xfer_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Samples handshake before the edge: pops the expected word on a transfer, pushes on accept.
  task automatic tick(output bit acc, output bit xf, output logic [W-1:0] got,
                      output logic gz, output logic gn, output logic [W-1:0] want,
                      output bit under);
    #1;
    acc   = in_valid && in_ready;
    xf    = out_valid && out_ready;
    got   = out_data;
    gz    = zr;
    gn    = ng;
    want  = '0;
    under = 1'b0;
    if (xf) begin
      if (sb.size() == 0) under = 1'b1;
      else want = sb.pop_front();
      exp_cnt = exp_cnt + 8'd1;
    end
    if (acc) sb.push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    exp_cnt = '0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    n_cmp++; if (zr !== 1'b0 || ng !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got zr=%b ng=%b want 0 0", zr, ng); end
    n_cmp++; if (xfer_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_xfer_cnt: got %0d want 0", xfer_cnt); end
    n_cmp++; if (sticky_nz !== 1'b0) begin n_bad++; $display("FAIL reset_sticky: got %b want 0", sticky_nz); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_latency();
    bit acc, xf, under;
    logic [W-1:0] got, want;
    logic gz, gn;
    in_valid = 1'b1; in_data = 16'h0000; out_ready = 1'b1;
    tick(acc, xf, got, gz, gn, want, under);
    n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL lat_accept: got %b want 1", acc); end
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_cycle1_valid: got %b want 0", out_valid); end
    tick(acc, xf, got, gz, gn, want, under);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL lat_cycle2_valid: got %b want 1", out_valid); end
    tick(acc, xf, got, gz, gn, want, under);
    n_cmp++;
    if (!xf || under || got !== 16'h0000 || gz !== 1'b1 || gn !== 1'b0) begin
      n_bad++;
      $display("FAIL lat_word: got xf=%b data=%h zr=%b ng=%b want xf=1 data=0000 zr=1 ng=0", xf, got, gz, gn);
    end
    n_cmp++; if (xfer_cnt !== 8'd1) begin n_bad++; $display("FAIL lat_xfer_cnt: got %0d want 1", xfer_cnt); end
    n_cmp++; if (sticky_nz !== 1'b0) begin n_bad++; $display("FAIL lat_sticky_zero_word: got %b want 0", sticky_nz); end
  endtask

  task automatic test_flags();
    logic [W-1:0] words[4] = '{16'h0001, 16'h8000, 16'h0100, 16'hFFFF};
    bit nt[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit acc, xf, under;
    logic [W-1:0] got, want;
    logic gz, gn;
    int ia = 0, io = 0, fa = -1, la = -1, fo = -1, lo = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && io < 4; c++) begin
      in_valid = (ia < 4);
      in_data  = (ia < 4) ? words[ia] : '0;
      tick(acc, xf, got, gz, gn, want, under);
      if (acc) begin if (fa < 0) fa = c; la = c; ia++; end
      if (xf) begin
        n_cmp++;
        if (under || got !== want || gz !== 1'b0 || gn !== nt[io]) begin
          n_bad++;
          $display("FAIL flags_word%0d: got data=%h zr=%b ng=%b want data=%h zr=0 ng=%b", io, got, gz, gn, want, nt[io]);
        end
        if (fo < 0) fo = c; lo = c; io++;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (io != 4) begin n_bad++; $display("FAIL flags_count: got %0d outputs want 4", io); end
    n_cmp++; if (la - fa != 3) begin n_bad++; $display("FAIL flags_in_bubbles: got span %0d want 3", la - fa); end
    n_cmp++; if (lo - fo != 3) begin n_bad++; $display("FAIL flags_out_bubbles: got span %0d want 3", lo - fo); end
    n_cmp++; if (sticky_nz !== 1'b1) begin n_bad++; $display("FAIL flags_sticky: got %b want 1", sticky_nz); end
    n_cmp++; if (xfer_cnt !== exp_cnt) begin n_bad++; $display("FAIL flags_xfer_cnt: got %0d want %0d", xfer_cnt, exp_cnt); end
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] words[3] = '{16'h1234, 16'h00A0, 16'hC001};
    bit acc, xf, under;
    logic [W-1:0] got, want;
    logic gz, gn;
    int ia = 0, io = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (ia < 3);
      in_data  = (ia < 3) ? words[ia] : '0;
      tick(acc, xf, got, gz, gn, want, under);
      if (acc) ia++;
      if (c >= 1) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== words[0] || zr !== 1'b0 || ng !== 1'b0) begin
          n_bad++;
          $display("FAIL bp_hold_c%0d: got valid=%b data=%h zr=%b ng=%b want 1 %h 0 0", c, out_valid, out_data, zr, ng, words[0]);
        end
      end
    end
    n_cmp++; if (ia != 2) begin n_bad++; $display("FAIL bp_accepted: got %0d want 2", ia); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && io < 3; c++) begin
      in_valid = (ia < 3);
      in_data  = (ia < 3) ? words[ia] : '0;
      tick(acc, xf, got, gz, gn, want, under);
      if (acc) ia++;
      if (xf) begin
        n_cmp++;
        if (under || io > 2 || got !== words[io] || got !== want || gz !== (want == '0) || gn !== want[W-1]) begin
          n_bad++;
          $display("FAIL bp_order%0d: got data=%h zr=%b ng=%b want data=%h", io, got, gz, gn, want);
        end
        io++;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (io != 3 || sb.size() != 0) begin n_bad++; $display("FAIL bp_drain: got %0d outputs, %0d queued want 3, 0", io, sb.size()); end
  endtask

  task automatic send_with_clear(input logic [W-1:0] word, input string name);
    bit acc, xf, under;
    logic [W-1:0] got, want;
    logic gz, gn;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = word;
    tick(acc, xf, got, gz, gn, want, under);
    in_valid = 1'b0;
    for (int k = 0; k < 10 && !out_valid; k++) tick(acc, xf, got, gz, gn, want, under);
    clr_sticky = 1'b1;
    tick(acc, xf, got, gz, gn, want, under);
    clr_sticky = 1'b0;
    n_cmp++;
    if (!xf || under || got !== word || gz !== (word == '0)) begin
      n_bad++;
      $display("FAIL %s_xfer: got xf=%b data=%h zr=%b want xf=1 data=%h", name, xf, got, gz, word);
    end
  endtask

  task automatic test_sticky_race();
    send_with_clear(16'h0000, "race_zero");
    n_cmp++; if (sticky_nz !== 1'b0) begin n_bad++; $display("FAIL race_zero_sticky: got %b want 0", sticky_nz); end
    send_with_clear(16'h0040, "race_nz");
    n_cmp++; if (sticky_nz !== 1'b1) begin n_bad++; $display("FAIL race_nz_sticky: got %b want 1", sticky_nz); end
  endtask

  task automatic test_counter_wrap();
    bit acc, xf, under;
    logic [W-1:0] got, want;
    logic gz, gn;
    logic [7:0] c0;
    int ia = 0, io = 0;
    c0 = xfer_cnt;
    n_cmp++; if (c0 !== exp_cnt) begin n_bad++; $display("FAIL wrap_start_cnt: got %0d want %0d", c0, exp_cnt); end
    for (int c = 0; c < 2000 && io < 256; c++) begin
      in_valid  = (ia < 256);
      in_data   = (ia < 256) ? W'($urandom) : '0;
      out_ready = ($urandom_range(0, 3) != 0);
      tick(acc, xf, got, gz, gn, want, under);
      if (acc) ia++;
      if (xf) begin
        n_cmp++;
        if (under || got !== want || gz !== (want == '0) || gn !== want[W-1]) begin
          n_bad++;
          $display("FAIL wrap_word%0d: got data=%h zr=%b ng=%b want data=%h", io, got, gz, gn, want);
        end
        io++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++; if (io != 256) begin n_bad++; $display("FAIL wrap_count: got %0d transfers want 256", io); end
    n_cmp++; if (xfer_cnt !== c0) begin n_bad++; $display("FAIL wrap_cnt: got %0d want %0d", xfer_cnt, c0); end
  endtask

  task automatic test_reset_mid();
    bit acc, xf, under;
    logic [W-1:0] got, want;
    logic gz, gn;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h5555;
    tick(acc, xf, got, gz, gn, want, under);
    in_data = 16'h7777;
    tick(acc, xf, got, gz, gn, want, under);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_full: got out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    exp_cnt = '0;
    n_cmp++;
    if (out_valid !== 1'b0 || xfer_cnt !== 8'd0 || sticky_nz !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_state: got valid=%b cnt=%0d sticky=%b in_ready=%b want 0 0 0 1",
               out_valid, xfer_cnt, sticky_nz, in_ready);
    end
    for (int c = 0; c < 5; c++) begin
      tick(acc, xf, got, gz, gn, want, under);
      n_cmp++;
      if (xf) begin n_bad++; $display("FAIL rstmid_stale%0d: got stale word %h want none", c, got); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_flags();
    test_back_pressure();
    test_sticky_race();
    test_counter_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
